// File: rtl/sine_table_loader_pkg.sv
// Shared sine-table constants and loader state encoding, also used by the waveform stage.
// SINE_TABLE_LOADER_CHECKSUM_EN adds the CHECK state used by checksum builds.
package sine_table_loader_pkg;

    localparam int unsigned SINE_TABLE_ADDR_WIDTH = 14;
    localparam int unsigned SINE_SAMPLE_WIDTH     = 15;
    localparam int unsigned HOST_WORD_WIDTH       = 16;
    localparam int unsigned CHECKSUM_WIDTH        = 16;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_LOAD  = 3'd1,
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        LDR_CHECK = 3'd2,
`endif
        LDR_DONE  = 3'd3,
        LDR_ERROR = 3'd4
    } loader_state_e;

    // States in which the loader owns the host stream.
    function automatic logic loader_busy(input loader_state_e s);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        return (s == LDR_LOAD) || (s == LDR_CHECK);
`else
        return (s == LDR_LOAD);
`endif
    endfunction

endpackage

// File: rtl/sine_loader_checksum.sv
// Running 16-bit wrap-around sum of accepted samples, compared against the host trailer word.
// Instantiated by sine_table_loader only when SINE_TABLE_LOADER_CHECKSUM_EN is defined.
module sine_loader_checksum
    import sine_table_loader_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SINE_SAMPLE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      add,
    input  logic [SAMPLE_WIDTH-1:0]   sample,
    input  logic [CHECKSUM_WIDTH-1:0] trailer,
    output logic                      match_c
);

    logic [CHECKSUM_WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + CHECKSUM_WIDTH'(sample);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign match_c = (sum_q == trailer);

endmodule

// File: rtl/sine_table_loader.sv
// Streams host words into the external quarter-wave sine table RAM (write side only).
// Define SINE_TABLE_LOADER_CHECKSUM_EN to require a trailing checksum word before DONE.
module sine_table_loader
    import sine_table_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = SINE_TABLE_ADDR_WIDTH,
    parameter int unsigned SAMPLE_WIDTH = SINE_SAMPLE_WIDTH
) (
    input  logic                       i_Clock,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic                       i_DataValid,
    input  logic [HOST_WORD_WIDTH-1:0] i_Data,
    output logic                       o_DataReady,
    output logic                       o_WriteEnable,
    output logic [ADDR_WIDTH-1:0]      o_WriteAddress,
    output logic [SAMPLE_WIDTH-1:0]    o_WriteData,
    output logic                       o_Busy,
    output logic                       o_Done,
    output logic                       o_Error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    loader_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]     count_q, count_d;
    logic                      ready_q, ready_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     waddr_q, waddr_d;
    logic [SAMPLE_WIDTH-1:0]   wdata_q, wdata_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      error_q, error_d;

    logic                      start_c;
    logic                      accept_c;
    logic                      bad_word_c;
    logic                      last_word_c;
    logic [SAMPLE_WIDTH-1:0]   sample_c;

    assign start_c     = i_Start && !loader_busy(state_q);
    assign accept_c    = i_DataValid && ready_q;
    assign bad_word_c  = i_Data[HOST_WORD_WIDTH-1];
    assign last_word_c = (count_q == LAST_ADDR);
    assign sample_c    = i_Data[SAMPLE_WIDTH-1:0];

`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
    logic sum_add_c;
    logic sum_match_c;

    assign sum_add_c = (state_q == LDR_LOAD) && accept_c && !bad_word_c;

    sine_loader_checksum #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_checksum (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .clear   (start_c),
        .add     (sum_add_c),
        .sample  (sample_c),
        .trailer (i_Data),
        .match_c (sum_match_c)
    );
`endif

    // Next state, write request and registered status flags.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;

        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                if (start_c) begin
                    state_d = LDR_LOAD;
                    count_d = '0;
                end
            end
            LDR_LOAD: begin
                if (accept_c) begin
                    if (bad_word_c) begin
                        state_d = LDR_ERROR;
                    end else begin
                        we_d    = 1'b1;
                        waddr_d = count_q;
                        wdata_d = sample_c;
                        count_d = count_q + ADDR_WIDTH'(1);
                        if (last_word_c) begin
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
                            state_d = LDR_CHECK;
`else
                            state_d = LDR_DONE;
`endif
                        end
                    end
                end
            end
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
            LDR_CHECK: begin
                if (accept_c) begin
                    state_d = sum_match_c ? LDR_DONE : LDR_ERROR;
                end
            end
`endif
            default: begin
                state_d = LDR_IDLE;
            end
        endcase

        ready_d = loader_busy(state_d);
        busy_d  = loader_busy(state_d);
        // Done waits one cycle in DONE so the final RAM write has landed first.
        done_d  = (state_q == LDR_DONE) && (state_d == LDR_DONE);
        error_d = (state_d == LDR_ERROR);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= LDR_IDLE;
            count_q <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign o_DataReady    = ready_q;
    assign o_WriteEnable  = we_q;
    assign o_WriteAddress = waddr_q;
    assign o_WriteData    = wdata_q;
    assign o_Busy         = busy_q;
    assign o_Done         = done_q;
    assign o_Error        = error_q;

endmodule

// File: tb/tb_sine_table_loader.sv
// Self-checking bench for sine_table_loader: short vector table plus full-table load sequences.
// Checksum sequences are exercised when SINE_TABLE_LOADER_CHECKSUM_EN is defined.
module tb_sine_table_loader;

    localparam int DEPTH = 16384;

    logic        i_Clock;
    logic        i_Reset;
    logic        i_Start;
    logic        i_DataValid;
    logic [15:0] i_Data;
    logic        o_DataReady;
    logic        o_WriteEnable;
    logic [13:0] o_WriteAddress;
    logic [14:0] o_WriteData;
    logic        o_Busy;
    logic        o_Done;
    logic        o_Error;

    sine_table_loader dut (
        .i_Clock        (i_Clock),
        .i_Reset        (i_Reset),
        .i_Start        (i_Start),
        .i_DataValid    (i_DataValid),
        .i_Data         (i_Data),
        .o_DataReady    (o_DataReady),
        .o_WriteEnable  (o_WriteEnable),
        .o_WriteAddress (o_WriteAddress),
        .o_WriteData    (o_WriteData),
        .o_Busy         (o_Busy),
        .o_Done         (o_Done),
        .o_Error        (o_Error)
    );

    initial i_Clock = 1'b0;
    always #5 i_Clock = ~i_Clock;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream content: address itself, or constant 1 for the checksum streams.
    bit data_mode = 1'b0;
    function automatic logic [15:0] gen(input int idx);
        return data_mode ? 16'h0001 : 16'(idx & 32'h7FFF);
    endfunction

    // Write monitor: every strobe must follow an accepted good load word, in address order.
    bit mon_en = 1'b0;
    int mon_writes = 0;
    bit acc_prev = 1'b0;
    bit bad_prev = 1'b0;
    bit load_prev = 1'b0;

    always @(negedge i_Clock) begin
        logic        exp_we;
        logic [15:0] w;
        if (mon_en) begin
            exp_we = acc_prev && !bad_prev && load_prev;
            check("wr_strobe", 32'(o_WriteEnable), 32'(exp_we));
            if (o_WriteEnable) begin
                w = gen(mon_writes);
                check("wr_addr", 32'(o_WriteAddress), 32'(mon_writes));
                check("wr_data", 32'(o_WriteData), 32'(w & 16'h7FFF));
                mon_writes++;
            end
        end
        acc_prev  = i_DataValid && o_DataReady;
        bad_prev  = i_Data[15];
        load_prev = (mon_writes < DEPTH);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        valid;
        logic [15:0] data;
        logic        we;
        logic [13:0] addr;
        logic [14:0] wdata;
        logic        busy;
        logic        ready;
        logic        done;
        logic        error;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check_idle(input string tag);
        check({tag, "_we"},    32'(o_WriteEnable),  32'd0);
        check({tag, "_ready"}, 32'(o_DataReady),    32'd0);
        check({tag, "_busy"},  32'(o_Busy),         32'd0);
        check({tag, "_done"},  32'(o_Done),         32'd0);
        check({tag, "_error"}, 32'(o_Error),        32'd0);
        check({tag, "_addr"},  32'(o_WriteAddress), 32'd0);
        check({tag, "_data"},  32'(o_WriteData),    32'd0);
    endtask

    task automatic do_start();
        i_Start = 1'b1;
        @(posedge i_Clock); #1;
        i_Start = 1'b0;
        check("start_busy",  32'(o_Busy),      32'd1);
        check("start_ready", 32'(o_DataReady), 32'd1);
        check("start_done",  32'(o_Done),      32'd0);
        check("start_error", 32'(o_Error),     32'd0);
    endtask

    // One word per accepted cycle; optional idle gap after each word.
    task automatic stream(input int n, input bit toggle, input int bad_at, input int start_at);
        for (int i = 0; i < n; i++) begin
            if (o_DataReady !== 1'b1) begin
                check("stream_ready", 32'(o_DataReady), 32'd1);
                break;
            end
            i_Start     = (i == start_at);
            i_DataValid = 1'b1;
            i_Data      = (i == bad_at) ? 16'h8000 : gen(i);
            @(posedge i_Clock); #1;
            i_Start = 1'b0;
            if (toggle && i != n - 1) begin
                i_DataValid = 1'b0;
                i_Data      = 16'hFFFF;
                @(posedge i_Clock); #1;
                check("gap_busy", 32'(o_Busy), 32'd1);
            end
        end
        i_DataValid = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last sample.
    task automatic finish_load(input logic [15:0] trailer, input bit expect_done);
        check("last_we", 32'(o_WriteEnable), 32'd1);
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        check("check_busy",  32'(o_Busy),      32'd1);
        check("check_ready", 32'(o_DataReady), 32'd1);
        i_DataValid = 1'b1;
        i_Data      = trailer;
        @(posedge i_Clock); #1;
        i_DataValid = 1'b0;
        check("trailer_we", 32'(o_WriteEnable), 32'd0);
`else
        check("trailer_unused", 32'(trailer & 16'h0), 32'(o_Done));
`endif
        check("end_busy",  32'(o_Busy),      32'd0);
        check("end_ready", 32'(o_DataReady), 32'd0);
        check("end_done0", 32'(o_Done),      32'd0);
        check("end_error", 32'(o_Error),     32'(!expect_done));
        @(posedge i_Clock); #1;
        check("end_done1", 32'(o_Done),          32'(expect_done));
        check("end_we",    32'(o_WriteEnable),   32'd0);
    endtask

    initial begin
        i_Reset     = 1'b1;
        i_Start     = 1'b0;
        i_DataValid = 1'b0;
        i_Data      = 16'h0000;

        //           rst   start valid data     we    addr   wdata     busy  ready done  error
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0005, 1'b1, 14'd0, 15'h0005, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b0, 14'd0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 14'd1, 15'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0123, 1'b1, 14'd2, 15'h0123, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 14'd0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0042, 1'b0, 14'd0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd0, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 14'd0, 15'h1111, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 14'd0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 14'd0, 15'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (2) @(posedge i_Clock);
        #1;
        check_idle("rst");
        i_Reset = 1'b0;
        @(posedge i_Clock); #1;
        check_idle("post_rst");

        for (int k = 0; k < NV; k++) begin
            i_Reset     = vecs[k].rst;
            i_Start     = vecs[k].start;
            i_DataValid = vecs[k].valid;
            i_Data      = vecs[k].data;
            @(posedge i_Clock); #1;
            check($sformatf("vec%0d_we", k),    32'(o_WriteEnable), 32'(vecs[k].we));
            check($sformatf("vec%0d_busy", k),  32'(o_Busy),        32'(vecs[k].busy));
            check($sformatf("vec%0d_ready", k), 32'(o_DataReady),   32'(vecs[k].ready));
            check($sformatf("vec%0d_done", k),  32'(o_Done),        32'(vecs[k].done));
            check($sformatf("vec%0d_error", k), 32'(o_Error),       32'(vecs[k].error));
            if (vecs[k].we) begin
                check($sformatf("vec%0d_addr", k), 32'(o_WriteAddress), 32'(vecs[k].addr));
                check($sformatf("vec%0d_data", k), 32'(o_WriteData),    32'(vecs[k].wdata));
            end
        end
        i_Start     = 1'b0;
        i_DataValid = 1'b0;

        // Full load, valid always high, stray start at word 10.
        data_mode  = 1'b0;
        mon_writes = 0;
        mon_en     = 1'b1;
        do_start();
        stream(DEPTH, 1'b0, -1, 10);
        finish_load(16'hE000, 1'b1);
        check("full_writes", 32'(mon_writes), 32'(DEPTH));

        // Bad word at index 100 aborts after exactly 100 writes.
        mon_writes = 0;
        do_start();
        stream(101, 1'b0, 100, -1);
        check("abort_error", 32'(o_Error),       32'd1);
        check("abort_busy",  32'(o_Busy),        32'd0);
        check("abort_we",    32'(o_WriteEnable), 32'd0);
        repeat (2) @(posedge i_Clock);
        #1;
        check("abort_writes", 32'(mon_writes), 32'd100);
        check("abort_hold",   32'(o_Error),    32'd1);

        // Clean reload with valid toggling.
`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        data_mode = 1'b1;
`endif
        mon_writes = 0;
        do_start();
        stream(DEPTH, 1'b1, -1, -1);
        finish_load(data_mode ? 16'h4000 : 16'hE000, 1'b1);
        check("toggle_writes", 32'(mon_writes), 32'(DEPTH));

        // Reset after 5000 writes.
        data_mode  = 1'b0;
        mon_writes = 0;
        do_start();
        stream(5000, 1'b0, -1, -1);
        @(negedge i_Clock); #1;
        i_Reset = 1'b1;
        #1;
        check_idle("midrst");
        i_DataValid = 1'b1;
        i_Data      = 16'h0055;
        repeat (3) @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        repeat (5) @(posedge i_Clock);
        #1;
        i_DataValid = 1'b0;
        check("midrst_writes", 32'(mon_writes), 32'd5000);
        check("midrst_done",   32'(o_Done),     32'd0);
        check("midrst_busy",   32'(o_Busy),     32'd0);

`ifdef SINE_TABLE_LOADER_CHECKSUM_EN
        // Checksum mismatch: trailer 0x4001 against sum 0x4000.
        data_mode  = 1'b1;
        mon_writes = 0;
        do_start();
        stream(DEPTH, 1'b0, -1, -1);
        finish_load(16'h4001, 1'b0);
        check("cksum_bad_writes", 32'(mon_writes), 32'(DEPTH));
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
